// File: rtl/counter_sync_updown_mod_if.sv
// Control/status bundle for counter_sync_updown_mod: step/load controls in, count/Tc/Ovf out.
// Handshake: no valid/ready pair; En qualifies one step per Clk edge, Load qualifies LoadVal on that edge.
interface counter_sync_updown_mod_if #(
  parameter int WIDTH = 4
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] count;
  logic             Tc;
  logic             Ovf;

  modport master (
    output En, Up, Load, LoadVal,
    input  count, Tc, Ovf
  );

  modport slave (
    input  En, Up, Load, LoadVal,
    output count, Tc, Ovf
  );
endinterface

// File: rtl/counter_sync_updown_mod.sv
// Synchronous up/down modulo-MODULUS counter with clamped load, wrap or saturate boundaries,
// combinational terminal count for cascading and a sticky overflow/underflow flag.
module counter_sync_updown_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic                     Clk,
  input  logic                     Clr,
  counter_sync_updown_mod_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("counter_sync_updown_mod: WIDTH %0d outside 2..16", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("counter_sync_updown_mod: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  if ($bits(bus.count) != WIDTH) begin : g_bad_if_width
    $error("counter_sync_updown_mod: interface WIDTH does not match counter WIDTH");
  end

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] load_val;
  logic             at_top;
  logic             at_bot;

  // A full binary modulus cannot see an out-of-range load, so the clamp compare is omitted there.
  if (MODULUS == (1 << WIDTH)) begin : g_no_clamp
    assign load_val = bus.LoadVal;
  end else begin : g_clamp
    assign load_val = (bus.LoadVal > CNT_MAX) ? CNT_MAX : bus.LoadVal;
  end

  assign at_top = (count_q == CNT_MAX);
  assign at_bot = (count_q == CNT_ZERO);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.Load) begin
      count_d = load_val;
      ovf_d   = 1'b0;
    end else if (bus.En) begin
      if (bus.Up) begin
        if (at_top) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? count_q : CNT_ZERO;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        if (at_bot) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? count_q : CNT_MAX;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Tc deliberately ignores Load so a cascade sees the boundary from En/Up/count alone.
  assign bus.Tc    = bus.En & ((bus.Up & at_top) | (~bus.Up & at_bot));
  assign bus.count = count_q;
  assign bus.Ovf   = ovf_q;

endmodule

// File: tb/tb_counter_sync_updown_mod.sv
// Directed bench for counter_sync_updown_mod: wrap and saturate builds at MODULUS=10 plus a
// two-stage MODULUS=16 cascade.
module tb_counter_sync_updown_mod;

  logic Clk;
  logic clr_w;
  logic clr_s;
  logic clr_c;
  int   tests;
  int   fails;

  counter_sync_updown_mod_if #(.WIDTH(4)) w_if ();
  counter_sync_updown_mod_if #(.WIDTH(4)) s_if ();
  counter_sync_updown_mod_if #(.WIDTH(4)) c0_if ();
  counter_sync_updown_mod_if #(.WIDTH(4)) c1_if ();

  counter_sync_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .Clk(Clk), .Clr(clr_w), .bus(w_if.slave)
  );
  counter_sync_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .Clk(Clk), .Clr(clr_s), .bus(s_if.slave)
  );
  counter_sync_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c0 (
    .Clk(Clk), .Clr(clr_c), .bus(c0_if.slave)
  );
  counter_sync_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c1 (
    .Clk(Clk), .Clr(clr_c), .bus(c1_if.slave)
  );

  assign c1_if.En = c0_if.Tc;

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int exp_up_cnt  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn_cnt  [4]  = '{1, 0, 0, 0};
  int exp_dn_tc   [4]  = '{0, 0, 1, 1};
  int exp_dn_ovf  [4]  = '{0, 0, 1, 1};
  int gate_en     [6]  = '{1, 0, 1, 1, 1, 1};
  int gate_up     [6]  = '{1, 1, 1, 0, 0, 0};
  int gate_cnt    [6]  = '{6, 6, 7, 6, 5, 4};

  initial begin
    tests = 0;
    fails = 0;

    // reset with Load and En active
    clr_w = 1'b1; clr_s = 1'b1; clr_c = 1'b1;
    w_if.En = 1'b1; w_if.Up = 1'b1; w_if.Load = 1'b1; w_if.LoadVal = 4'd7;
    s_if.En = 1'b1; s_if.Up = 1'b1; s_if.Load = 1'b1; s_if.LoadVal = 4'd7;
    c0_if.En = 1'b1; c0_if.Up = 1'b1; c0_if.Load = 1'b0; c0_if.LoadVal = 4'd0;
    c1_if.Up = 1'b1; c1_if.Load = 1'b0; c1_if.LoadVal = 4'd0;
    tick();
    check("rst1_count", 32'(w_if.count), 32'd0);
    check("rst1_ovf", 32'(w_if.Ovf), 32'd0);
    check("rst1_tc", 32'(w_if.Tc), 32'd0);
    check("rst1_sat_count", 32'(s_if.count), 32'd0);
    tick();
    check("rst2_count", 32'(w_if.count), 32'd0);
    check("rst2_ovf", 32'(w_if.Ovf), 32'd0);

    // up wrap, 12 edges
    clr_w = 1'b0; w_if.Load = 1'b0; w_if.En = 1'b1; w_if.Up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      settle();
      check($sformatf("up_tc_%0d", k), 32'(w_if.Tc), (k == 9) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("up_cnt_%0d", k), 32'(w_if.count), 32'(exp_up_cnt[k]));
      check($sformatf("up_ovf_%0d", k), 32'(w_if.Ovf), (k >= 9) ? 32'd1 : 32'd0);
    end
    w_if.En = 1'b0;

    // saturating build: load 2, count down into the floor
    clr_s = 1'b0; s_if.Load = 1'b1; s_if.LoadVal = 4'd2; s_if.En = 1'b0; s_if.Up = 1'b1;
    tick();
    check("sat_load_cnt", 32'(s_if.count), 32'd2);
    check("sat_load_ovf", 32'(s_if.Ovf), 32'd0);
    s_if.Load = 1'b0; s_if.Up = 1'b0; s_if.En = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("sat_dn_tc_%0d", k), 32'(s_if.Tc), 32'(exp_dn_tc[k]));
      tick();
      check($sformatf("sat_dn_cnt_%0d", k), 32'(s_if.count), 32'(exp_dn_cnt[k]));
      check($sformatf("sat_dn_ovf_%0d", k), 32'(s_if.Ovf), 32'(exp_dn_ovf[k]));
    end
    s_if.Up = 1'b1;
    settle();
    check("sat_release_tc", 32'(s_if.Tc), 32'd0);
    tick();
    check("sat_release_cnt", 32'(s_if.count), 32'd1);
    check("sat_release_ovf", 32'(s_if.Ovf), 32'd1);
    s_if.Load = 1'b1; s_if.LoadVal = 4'd9;
    tick();
    check("sat_load9_cnt", 32'(s_if.count), 32'd9);
    check("sat_load9_ovf", 32'(s_if.Ovf), 32'd0);
    s_if.Load = 1'b0;
    settle();
    check("sat_top_tc", 32'(s_if.Tc), 32'd1);
    tick();
    check("sat_top_cnt", 32'(s_if.count), 32'd9);
    check("sat_top_ovf", 32'(s_if.Ovf), 32'd1);
    s_if.En = 1'b0;

    // load clamp, load-beats-terminal, clear-beats-load (wrap build sits at 2, Ovf=1)
    w_if.Load = 1'b1; w_if.LoadVal = 4'd13; w_if.En = 1'b1; w_if.Up = 1'b1;
    tick();
    check("clamp13_cnt", 32'(w_if.count), 32'd9);
    check("clamp13_ovf", 32'(w_if.Ovf), 32'd0);
    w_if.LoadVal = 4'd3;
    settle();
    check("load_at_top_tc", 32'(w_if.Tc), 32'd1);
    tick();
    check("load_at_top_cnt", 32'(w_if.count), 32'd3);
    check("load_at_top_ovf", 32'(w_if.Ovf), 32'd0);
    w_if.LoadVal = 4'd9;
    tick();
    check("load9_cnt", 32'(w_if.count), 32'd9);
    w_if.LoadVal = 4'd15;
    tick();
    check("clamp15_cnt", 32'(w_if.count), 32'd9);
    clr_w = 1'b1; w_if.LoadVal = 4'd5;
    tick();
    check("clr_over_load_cnt", 32'(w_if.count), 32'd0);
    check("clr_over_load_ovf", 32'(w_if.Ovf), 32'd0);
    clr_w = 1'b0;

    // enable gating and reversal from 5
    w_if.Load = 1'b1; w_if.LoadVal = 4'd5; w_if.En = 1'b0;
    tick();
    check("gate_load_cnt", 32'(w_if.count), 32'd5);
    w_if.Load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w_if.En = gate_en[k][0];
      w_if.Up = gate_up[k][0];
      settle();
      check($sformatf("gate_tc_%0d", k), 32'(w_if.Tc), 32'd0);
      tick();
      check($sformatf("gate_cnt_%0d", k), 32'(w_if.count), 32'(gate_cnt[k]));
      check($sformatf("gate_ovf_%0d", k), 32'(w_if.Ovf), 32'd0);
    end

    // down wrap, hold while disabled, reversal at the terminal value
    w_if.Load = 1'b1; w_if.LoadVal = 4'd0; w_if.En = 1'b0;
    tick();
    w_if.Load = 1'b0; w_if.Up = 1'b0; w_if.En = 1'b1;
    settle();
    check("dn_wrap_tc", 32'(w_if.Tc), 32'd1);
    tick();
    check("dn_wrap_cnt", 32'(w_if.count), 32'd9);
    check("dn_wrap_ovf", 32'(w_if.Ovf), 32'd1);
    w_if.En = 1'b0;
    settle();
    check("hold_tc", 32'(w_if.Tc), 32'd0);
    tick();
    w_if.Up = 1'b1;
    tick();
    check("hold_cnt", 32'(w_if.count), 32'd9);
    check("hold_ovf", 32'(w_if.Ovf), 32'd1);
    w_if.En = 1'b1; w_if.Up = 1'b0;
    settle();
    check("rev_top_tc", 32'(w_if.Tc), 32'd0);
    tick();
    check("rev_top_cnt", 32'(w_if.count), 32'd8);
    w_if.Up = 1'b1;
    tick();
    check("rev_back_cnt", 32'(w_if.count), 32'd9);
    settle();
    check("rev_back_tc", 32'(w_if.Tc), 32'd1);
    w_if.En = 1'b0;

    // two-stage cascade, 300 edges from reset
    clr_c = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      settle();
      check($sformatf("casc_tc_%0d", n), 32'(c0_if.Tc), (((n - 1) % 16) == 15) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("casc_val_%0d", n), 32'({c1_if.count, c0_if.count}), 32'(n % 256));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_sync_updown_mod.md
Name: counter_sync_updown_mod

Overview:
- Parametrised synchronous up/down modulo counter. It is the successor to the 4-bit ripple-clock D-flip-flop up counter.
- All flops share one clock. No derived or rippled clocks.
- Adds configurable width and modulus, direction control, parallel load, count enable, wrap-or-saturate mode, a terminal-count output and a sticky overflow flag.
- Used as a timebase, divider or event counter in the counter family.

Parameters:
- WIDTH, 4, bit width of count. Legal range is 2 to 16.
- MODULUS, 16, number of states; count range is 0..MODULUS-1. Legal range is 2 to 2**WIDTH. Elaboration error if out of range.
- SATURATE, 0, boundary mode. 0 = wrap around. 1 = hold at the terminal value.

Ports:
- Clk  input  1  rising-edge clock.
- Clr  input  1  synchronous reset, active-high.
- En  input  1  count enable; one step per Clk edge while high.
- Up  input  1  direction. 1 = increment, 0 = decrement.
- Load  input  1  synchronous parallel load.
- LoadVal  input  WIDTH  value captured on Load.
- count  output  WIDTH  registered count value.
- Tc  output  1  combinational terminal-count indication.
- Ovf  output  1  registered sticky overflow/underflow flag.

Behaviour:
- Only the rising edge of Clk is used. Clr is sampled only on that edge; there is no asynchronous path.
- Reset: while Clr is high at an edge, count <= 0 and Ovf <= 0. Tc then follows from the count=0 state.
- Priority per edge, highest first: Clr, then Load, then En. Lower-priority inputs are ignored in that cycle.
- Load:
  - count <= LoadVal if LoadVal <= MODULUS-1; otherwise count <= MODULUS-1 (clamp).
  - Ovf <= 0.
  - Load takes effect regardless of En and Up.
- Count step, when En=1 and Clr=0 and Load=0:
  - Up=1, count < MODULUS-1: count <= count+1.
  - Up=0, count > 0: count <= count-1.
  - Up=1, count = MODULUS-1 (terminal): SATURATE=0 gives count <= 0; SATURATE=1 holds count. Ovf <= 1 in both cases.
  - Up=0, count = 0 (terminal): SATURATE=0 gives count <= MODULUS-1; SATURATE=1 holds count. Ovf <= 1 in both cases.
- En=0 (and no Clr/Load): count and Ovf hold. Up may change freely.
- Tc = En & ((Up & count==MODULUS-1) | (~Up & count==0)).
  - Combinational; zero latency from En and Up.
  - Asserted in exactly the cycle whose edge wraps or saturates.
  - Intended for cascading into the next stage's En.
- Ovf is sticky once set. It is cleared only by Clr or Load.
- Latency: count, and any Ovf update, are visible one Clk edge after the controlling inputs are sampled.
- Arithmetic: modulo-MODULUS only; the counter never enters states >= MODULUS. For MODULUS = 2**WIDTH the wrap is natural binary wrap.
- Direction reversal takes effect on the next edge with no lost or extra step. A reversal in the same cycle as a terminal state uses the new Up for both the step and Tc.
- Reset mid-count: an edge with Clr=1 overrides a simultaneous Load and En. The next edge with Clr=0 resumes from count=0.
- Simultaneous Load and terminal step: the load wins, and Ovf is cleared rather than set.
- No X-propagation tolerance is required on En, Up or Load after reset.

Test Plan:
- Reset and idle:
  - Stimulus: WIDTH=4, MODULUS=10, SATURATE=0. Clr=1 for 2 edges with En=1, Load=1, LoadVal=7.
  - Required: count=0, Ovf=0 after the first edge. Tc=0 while Up=1.
- Up wrap:
  - Stimulus: Clr released, En=1, Up=1 for 12 edges.
  - Required: count runs 1..9, 0, 1, 2. Tc high only in the cycle count=9. Ovf rises on the 9->0 edge and stays 1.
- Down and saturate:
  - Stimulus: SATURATE=1 build, Load LoadVal=2, then Up=0, En=1 for 4 edges.
  - Required: count runs 2, 1, 0, 0, 0. Tc=1 while count=0. Ovf=1 from the first held edge. Up=1 then releases the hold to 1.
- Load clamp and priority:
  - Stimulus: MODULUS=10, Load=1 with LoadVal=13 and En=1.
  - Required: count=9, Ovf cleared.
  - Stimulus: Load=1 and Clr=1 together.
  - Required: count=0.
- Enable gating and reversal:
  - Stimulus: from count=5, toggle En 1,0,1 with Up=1, then Up=0 for 3 edges.
  - Required: count runs 6, 6, 7, then 6, 5, 4. No Tc pulses.
- Full-range cascade:
  - Stimulus: WIDTH=4, MODULUS=16. Two instances, with stage-1 En driven by stage-0 Tc, run for 300 edges from reset.
  - Required: the combined value equals the edge count mod 256, and the high stage increments exactly when the low stage wraps 15->0.
